// File: rtl/sc_lives_manager.sv
// Lives tracker for the Frogger core: start/die/bonus edge events drive a small
// FSM that loads, decrements and saturates the life count and times a grace window.
//
// state | meaning
// IDLE  | waiting for the first start event, lives held at 0
// PLAY  | normal play, deaths and bonuses accepted
// GRACE | post-death invulnerability, timer counting down to 0
// OVER  | no lives left, waiting for a start event
module sc_lives_manager #(
    parameter int LIVES_DATAWIDTH = 3,
    parameter int LIVES_INIT      = 3,
    parameter int LIVES_MAX       = 7,
    parameter int GRACE_CYCLES    = 25000000,
    parameter int GRACE_WIDTH     = 25
) (
    input  logic                       SC_LIVES_MANAGER_CLOCK_50,
    input  logic                       SC_LIVES_MANAGER_RESET_InHigh,
    input  logic                       SC_LIVES_MANAGER_start_InLow,
    input  logic                       SC_LIVES_MANAGER_die_InLow,
    input  logic                       SC_LIVES_MANAGER_bonus_InLow,
    output logic [LIVES_DATAWIDTH-1:0] SC_LIVES_MANAGER_lives_Out,
    output logic [1:0]                 SC_LIVES_MANAGER_state_Out,
    output logic                       SC_LIVES_MANAGER_grace_OutHigh,
    output logic                       SC_LIVES_MANAGER_gameover_OutHigh,
    output logic                       SC_LIVES_MANAGER_lifelost_OutHigh
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_GRACE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [LIVES_DATAWIDTH-1:0] LIVES_INIT_C = LIVES_DATAWIDTH'(LIVES_INIT);
    localparam logic [LIVES_DATAWIDTH-1:0] LIVES_MAX_C  = LIVES_DATAWIDTH'(LIVES_MAX);
    localparam logic [LIVES_DATAWIDTH-1:0] LIVES_ONE_C  = LIVES_DATAWIDTH'(1);
    localparam logic [GRACE_WIDTH-1:0]     GRACE_LOAD_C = GRACE_WIDTH'(GRACE_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [LIVES_DATAWIDTH-1:0] lives_q, lives_d;
    logic [GRACE_WIDTH-1:0]     timer_q, timer_d;
    logic                       lifelost_q, lifelost_d;
    logic                       start_prev_q, die_prev_q, bonus_prev_q;

    logic                       start_ev, die_ev, bonus_ev;
    logic [LIVES_DATAWIDTH-1:0] lives_inc;

    assign start_ev  = start_prev_q & ~SC_LIVES_MANAGER_start_InLow;
    assign die_ev    = die_prev_q   & ~SC_LIVES_MANAGER_die_InLow;
    assign bonus_ev  = bonus_prev_q & ~SC_LIVES_MANAGER_bonus_InLow;
    assign lives_inc = (lives_q >= LIVES_MAX_C) ? LIVES_MAX_C : lives_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        timer_d    = timer_q;
        lifelost_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_INIT_C;
                end
            end
            ST_PLAY: begin
                if (die_ev) begin
                    lifelost_d = 1'b1;
                    // A simultaneous bonus refunds the life, so this path never reaches OVER.
                    if (bonus_ev) begin
                        state_d = ST_GRACE;
                        timer_d = GRACE_LOAD_C;
                    end else if (lives_q > LIVES_ONE_C) begin
                        lives_d = lives_q - 1'b1;
                        state_d = ST_GRACE;
                        timer_d = GRACE_LOAD_C;
                    end else begin
                        lives_d = '0;
                        state_d = ST_OVER;
                    end
                end else if (bonus_ev) begin
                    lives_d = lives_inc;
                end
            end
            ST_GRACE: begin
                if (bonus_ev) begin
                    lives_d = lives_inc;
                end
                if (timer_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_OVER: begin
                lives_d = '0;
                if (start_ev) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_INIT_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lives_d = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge SC_LIVES_MANAGER_CLOCK_50) begin
        if (SC_LIVES_MANAGER_RESET_InHigh) begin
            state_q      <= ST_IDLE;
            lives_q      <= '0;
            timer_q      <= '0;
            lifelost_q   <= 1'b0;
            start_prev_q <= 1'b1;
            die_prev_q   <= 1'b1;
            bonus_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            timer_q      <= timer_d;
            lifelost_q   <= lifelost_d;
            start_prev_q <= SC_LIVES_MANAGER_start_InLow;
            die_prev_q   <= SC_LIVES_MANAGER_die_InLow;
            bonus_prev_q <= SC_LIVES_MANAGER_bonus_InLow;
        end
    end

    assign SC_LIVES_MANAGER_lives_Out         = lives_q;
    assign SC_LIVES_MANAGER_state_Out         = state_q;
    assign SC_LIVES_MANAGER_grace_OutHigh     = (state_q == ST_GRACE);
    assign SC_LIVES_MANAGER_gameover_OutHigh  = (state_q == ST_OVER);
    assign SC_LIVES_MANAGER_lifelost_OutHigh  = lifelost_q;

endmodule
